// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy scene generator.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Fibonacci taps 8,6,5,4 mapped onto bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic        [9:0]  RST_BIRD_Y  = 10'd232;
  localparam logic signed [10:0] RST_PIPE0_X = 11'sd640;
  localparam logic signed [10:0] RST_PIPE1_X = 11'sd960;
  localparam logic        [9:0]  RST_GAP_TOP = 10'd176;

endpackage

// File: rtl/scene_gen_if.sv
// Pixel/frame/control bundle between the VGA side, the game controls and scene_gen.
interface scene_gen_if;
  logic       reset_game;
  logic       flap;
  logic       halt;
  logic       frame_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       bird_color;
  logic       pipe_color;
  logic [9:0] bird_y;
  logic [1:0] state;

  modport master (
    output reset_game, flap, halt, frame_tick, pixel_x, pixel_y,
    input  bird_color, pipe_color, bird_y, state
  );

  modport slave (
    input  reset_game, flap, halt, frame_tick, pixel_x, pixel_y,
    output bird_color, pipe_color, bird_y, state
  );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; only the async reset reseeds it.
module lfsr8
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value <= LFSR_SEED;
    else          value <= {value[6:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/scene_gen.sv
// Bird physics, scrolling pipes and game FSM; emits registered per-pixel colour flags.
//   state    | meaning
//   ST_READY | waiting for first flap, nothing moves
//   ST_PLAY  | physics and scrolling on every frame_tick
//   ST_DEAD  | frozen until reset_game
module scene_gen
  import flappy_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int BIRD_X       = 160,
  parameter int BIRD_SIZE    = 16,
  parameter int PIPE_W       = 64,
  parameter int GAP_H        = 128,
  parameter int PIPE_SPACING = 320,
  parameter int GRAVITY      = 1,
  parameter int FLAP_VEL     = -8,
  parameter int MAX_FALL     = 8,
  parameter int SCROLL       = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  scene_gen_if.slave io
);

  localparam logic signed [5:0]  GRAV_V   = 6'(GRAVITY);
  localparam logic signed [5:0]  FLAP_V   = 6'(FLAP_VEL);
  localparam logic signed [5:0]  MAX_V    = 6'(MAX_FALL);
  localparam logic signed [10:0] Y_MAX    = 11'(V_ACTIVE - BIRD_SIZE);
  localparam logic signed [10:0] SCROLL_X = 11'(SCROLL);
  localparam logic signed [10:0] WRAP_LIM = 11'(-PIPE_W);
  localparam logic signed [10:0] WRAP_ADD = 11'(2 * PIPE_SPACING);
  localparam logic signed [11:0] PIPE_W12 = 12'(PIPE_W);

  state_t             state_q;
  logic        [9:0]  bird_y_q;
  logic signed [5:0]  vel_q;
  logic signed [10:0] pipe_x_q [2];
  logic        [9:0]  gap_q [2];
  logic               latch_q, flap_prev_q;
  logic               bird_color_q, pipe_color_q;
  logic        [7:0]  lfsr_val;

  logic               flap_edge, flap_now;
  logic signed [5:0]  vel_inc, vel_next;
  logic signed [10:0] y_sum;
  logic signed [10:0] px_step [2];
  logic signed [10:0] px_next [2];
  logic        [1:0]  wrap;
  logic signed [11:0] pix_x12, pipe_lo;
  logic        [1:0]  pipe_hit;
  logic               visible, bird_hit;

  lfsr8 u_lfsr (.clk(clk), .reset_n(reset_n), .value(lfsr_val));

  always_comb begin
    flap_edge = io.flap & ~flap_prev_q;
    flap_now  = latch_q | flap_edge;
    vel_inc   = vel_q + GRAV_V;
    vel_next  = flap_now ? FLAP_V : ((vel_inc > MAX_V) ? MAX_V : vel_inc);
    y_sum     = $signed({1'b0, bird_y_q}) + $signed({{5{vel_next[5]}}, vel_next});
    pix_x12   = $signed({2'b00, io.pixel_x});
    visible   = (io.pixel_x < 10'(H_ACTIVE)) && (io.pixel_y < 10'(V_ACTIVE));
    bird_hit  = visible
              && (io.pixel_x >= 10'(BIRD_X)) && (io.pixel_x < 10'(BIRD_X + BIRD_SIZE))
              && ({1'b0, io.pixel_y} >= {1'b0, bird_y_q})
              && ({1'b0, io.pixel_y} <  {1'b0, bird_y_q} + 11'(BIRD_SIZE));
    pipe_lo   = '0;
    pipe_hit  = '0;
    wrap      = '0;
    for (int i = 0; i < 2; i++) begin
      px_step[i] = pipe_x_q[i] - SCROLL_X;
      wrap[i]    = px_step[i] <= WRAP_LIM;
      px_next[i] = wrap[i] ? px_step[i] + WRAP_ADD : px_step[i];
      pipe_lo    = $signed({pipe_x_q[i][10], pipe_x_q[i]});
      pipe_hit[i] = visible && (pix_x12 >= pipe_lo) && (pix_x12 < pipe_lo + PIPE_W12)
                  && (({1'b0, io.pixel_y} <  {1'b0, gap_q[i]})
                   || ({1'b0, io.pixel_y} >= {1'b0, gap_q[i]} + 11'(GAP_H)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_READY;
      bird_y_q     <= RST_BIRD_Y;
      vel_q        <= '0;
      pipe_x_q[0]  <= RST_PIPE0_X;
      pipe_x_q[1]  <= RST_PIPE1_X;
      gap_q[0]     <= RST_GAP_TOP;
      gap_q[1]     <= RST_GAP_TOP;
      latch_q      <= 1'b0;
      flap_prev_q  <= 1'b0;
      bird_color_q <= 1'b0;
      pipe_color_q <= 1'b0;
    end else begin
      flap_prev_q  <= io.flap;
      bird_color_q <= bird_hit;
      pipe_color_q <= |pipe_hit;
      if (io.reset_game) begin
        state_q      <= ST_READY;
        bird_y_q     <= RST_BIRD_Y;
        vel_q        <= '0;
        pipe_x_q[0]  <= RST_PIPE0_X;
        pipe_x_q[1]  <= RST_PIPE1_X;
        gap_q[0]     <= RST_GAP_TOP;
        gap_q[1]     <= RST_GAP_TOP;
        latch_q      <= 1'b0;
        bird_color_q <= 1'b0;
        pipe_color_q <= 1'b0;
      end else begin
        case (state_q)
          ST_READY: begin
            // latch stays set so the first PLAY tick applies the flap velocity
            if (flap_edge) begin
              state_q <= ST_PLAY;
              latch_q <= 1'b1;
            end
          end
          ST_PLAY: begin
            latch_q <= io.frame_tick ? 1'b0 : flap_now;
            if (io.halt) begin
              state_q <= ST_DEAD;
            end else if (io.frame_tick) begin
              if (y_sum < 0) begin
                bird_y_q <= '0;
                vel_q    <= '0;
              end else if (y_sum > Y_MAX) begin
                bird_y_q <= Y_MAX[9:0];
                vel_q    <= '0;
              end else begin
                bird_y_q <= y_sum[9:0];
                vel_q    <= vel_next;
              end
              for (int i = 0; i < 2; i++) begin
                pipe_x_q[i] <= px_next[i];
                if (wrap[i]) gap_q[i] <= 10'd48 + {2'b00, lfsr_val};
              end
            end
          end
          ST_DEAD: state_q <= ST_DEAD;
          default: state_q <= ST_READY;
        endcase
      end
    end
  end

  assign io.bird_color = bird_color_q;
  assign io.pipe_color = pipe_color_q;
  assign io.bird_y     = bird_y_q;
  assign io.state      = state_q;

endmodule

// File: tb/tb_scene_gen.sv
// Self-checking bench for scene_gen: constant vectors, directed corner sequences, random run against a game model.
module tb_scene_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  scene_gen_if io ();

  scene_gen dut (.clk(clk), .reset_n(reset_n), .io(io));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // game model: integer positions, state 0 READY / 1 PLAY / 2 DEAD
  int m_state, m_y, m_vel, m_lfsr;
  int m_px [2];
  int m_gap [2];
  bit m_latch, m_prev, m_bc, m_pc;

  typedef struct {
    int px;
    int py;
    bit bird;
    bit pipe;
  } vec_t;
  vec_t vecs [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  function automatic bit bird_at(input int px, input int py);
    return px < 640 && py < 480 && px >= 160 && px < 176 && py >= m_y && py < m_y + 16;
  endfunction

  function automatic bit pipe_at(input int px, input int py);
    bit hit = 0;
    for (int i = 0; i < 2; i++)
      if (px < 640 && py < 480 && px >= m_px[i] && px < m_px[i] + 64 &&
          (py < m_gap[i] || py >= m_gap[i] + 128)) hit = 1;
    return hit;
  endfunction

  task automatic model_reset_game();
    m_state = 0; m_y = 232; m_vel = 0;
    m_px[0] = 640; m_px[1] = 960;
    m_gap[0] = 176; m_gap[1] = 176;
    m_latch = 0; m_bc = 0; m_pc = 0;
  endtask

  task automatic model_edge();
    bit e, fl;
    int lf_now, px, py;
    px = int'(io.pixel_x);
    py = int'(io.pixel_y);
    e = io.flap && !m_prev;
    m_prev = io.flap;
    m_bc = bird_at(px, py);
    m_pc = pipe_at(px, py);
    lf_now = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    if (io.reset_game) model_reset_game();
    else if (m_state == 0) begin
      if (e) begin m_state = 1; m_latch = 1; end
    end else if (m_state == 1) begin
      fl = m_latch || e;
      m_latch = io.frame_tick ? 1'b0 : fl;
      if (io.halt) m_state = 2;
      else if (io.frame_tick) begin
        m_vel = fl ? -8 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
        m_y = m_y + m_vel;
        if (m_y < 0) begin m_y = 0; m_vel = 0; end
        else if (m_y > 464) begin m_y = 464; m_vel = 0; end
        for (int i = 0; i < 2; i++) begin
          m_px[i] -= 2;
          if (m_px[i] <= -64) begin
            m_px[i] += 640;
            m_gap[i] = 48 + lf_now;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      io.frame_tick = 1'b1; cyc();
      io.frame_tick = 1'b0; cyc(); cyc();
    end
  endtask

  task automatic set_pix(input int px, input int py);
    io.pixel_x = 10'(px);
    io.pixel_y = 10'(py);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".bird_y"}, int'(io.bird_y), m_y);
    check({tag, ".state"}, int'(io.state), m_state);
    check({tag, ".bird_color"}, int'(io.bird_color), int'(m_bc));
    check({tag, ".pipe_color"}, int'(io.pipe_color), int'(m_pc));
  endtask

  task automatic pulse_reset_game();
    io.reset_game = 1'b1; cyc();
    io.reset_game = 1'b0;
  endtask

  task automatic start_play();
    io.flap = 1'b1; cyc();
    io.flap = 1'b0; cyc();
  endtask

  initial begin
    io.reset_game = 0; io.flap = 0; io.halt = 0; io.frame_tick = 0;
    set_pix(0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_lfsr = 8'hA5; m_prev = 0;
    model_reset_game();

    check("rst.state", int'(io.state), 0);
    check("rst.bird_y", int'(io.bird_y), 232);
    check("rst.bird_color", int'(io.bird_color), 0);
    check("rst.pipe_color", int'(io.pipe_color), 0);

    vecs.push_back('{168, 240, 1'b1, 1'b0});
    vecs.push_back('{100,  10, 1'b0, 1'b0});
    vecs.push_back('{160, 232, 1'b1, 1'b0});
    vecs.push_back('{175, 247, 1'b1, 1'b0});
    vecs.push_back('{159, 240, 1'b0, 1'b0});
    vecs.push_back('{176, 240, 1'b0, 1'b0});
    vecs.push_back('{168, 231, 1'b0, 1'b0});
    vecs.push_back('{168, 248, 1'b0, 1'b0});
    vecs.push_back('{639,   0, 1'b0, 1'b0});
    foreach (vecs[i]) begin
      set_pix(vecs[i].px, vecs[i].py);
      cyc();
      check($sformatf("vec%0d.bird_color", i), int'(io.bird_color), int'(vecs[i].bird));
      check($sformatf("vec%0d.pipe_color", i), int'(io.pipe_color), int'(vecs[i].pipe));
    end

    tick_n(5);
    check("ready.bird_y", int'(io.bird_y), 232);
    check("ready.state", int'(io.state), 0);

    io.flap = 1'b1; cyc();
    check("flap.state", int'(io.state), 1);
    tick_n(1);
    check("flap1.bird_y", int'(io.bird_y), 224);
    tick_n(1);
    check("flap2.bird_y", int'(io.bird_y), 217);
    io.flap = 1'b0;
    tick_n(60);
    check("fall.bird_y", int'(io.bird_y), 464);
    tick_n(1);
    check("floor.bird_y", int'(io.bird_y), 464);
    check_model("fall");

    pulse_reset_game();
    check("rg.state", int'(io.state), 0);
    check("rg.bird_y", int'(io.bird_y), 232);
    start_play();
    tick_n(351);
    set_pix(1, 0); cyc();
    check("prewrap.edge_in", int'(io.pipe_color), 1);
    set_pix(2, 0); cyc();
    check("prewrap.edge_out", int'(io.pipe_color), 0);
    tick_n(1);
    set_pix(600, 0); cyc();
    check("wrap.pipe_600_0", int'(io.pipe_color), 1);
    set_pix(575, 0); cyc();
    check("wrap.pipe_575_0", int'(io.pipe_color), 0);
    set_pix(600, m_gap[0] - 1); cyc();
    check("wrap.above_gap", int'(io.pipe_color), 1);
    set_pix(600, m_gap[0]); cyc();
    check("wrap.gap_top", int'(io.pipe_color), 0);
    set_pix(600, m_gap[0] + 127); cyc();
    check("wrap.gap_bot", int'(io.pipe_color), 0);
    set_pix(600, m_gap[0] + 128); cyc();
    check("wrap.below_gap", int'(io.pipe_color), 1);
    check_model("wrap");

    pulse_reset_game();
    start_play();
    tick_n(3);
    check("prehalt.bird_y", int'(io.bird_y), 211);
    io.halt = 1'b1; io.frame_tick = 1'b1; cyc();
    io.halt = 1'b0; io.frame_tick = 1'b0;
    check("halt.state", int'(io.state), 2);
    check("halt.bird_y", int'(io.bird_y), 211);
    for (int k = 0; k < 3; k++) begin
      start_play();
      tick_n(1);
    end
    check("dead.state", int'(io.state), 2);
    check("dead.bird_y", int'(io.bird_y), 211);
    io.frame_tick = 1'b1; io.flap = 1'b1; io.halt = 1'b1;
    pulse_reset_game();
    io.frame_tick = 1'b0; io.flap = 1'b0; io.halt = 1'b0;
    cyc();
    check("restart.state", int'(io.state), 0);
    check("restart.bird_y", int'(io.bird_y), 232);
    start_play();
    tick_n(1);
    set_pix(638, 0); cyc();
    check("restart.pipe_638", int'(io.pipe_color), 1);
    set_pix(637, 0); cyc();
    check("restart.pipe_637", int'(io.pipe_color), 0);
    check_model("restart");

    tick_n(4);
    set_pix(168, m_y + 2); cyc();
    check("prerst.bird_color", int'(io.bird_color), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async.state", int'(io.state), 0);
    check("async.bird_y", int'(io.bird_y), 232);
    check("async.bird_color", int'(io.bird_color), 0);
    check("async.pipe_color", int'(io.pipe_color), 0);
    #1;
    reset_n = 1'b1;
    m_lfsr = 8'hA5; m_prev = 0;
    model_reset_game();

    for (int n = 0; n < 9000; n++) begin
      if ($urandom % 6 == 0) io.flap = ~io.flap;
      io.frame_tick = ($urandom % 5 == 0);
      io.halt       = ($urandom % 500 == 0);
      io.reset_game = ($urandom % 400 == 0);
      if ($urandom % 3 == 0) begin
        int py;
        py = m_y - 4 + int'($urandom % 24);
        if (py < 0) py = 0;
        if (py > 479) py = 479;
        set_pix(int'($urandom_range(150, 185)), py);
      end else begin
        set_pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
      end
      cyc();
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
